// File: rtl/nibble_pack.sv
// nibble_pack: packs a stream of 4-bit nibbles little-endian into words and queues them in a small FIFO.
// Optional NIBBLE_PACK_MAX_EN adds word_max_o, the largest nibble of the head word.
module nibble_pack #(
    parameter int NIBS       = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        nib_i,
    input  logic              nib_valid_i,
    output logic              nib_ready_o,
    input  logic              flush_i,
    output logic [4*NIBS-1:0] word_o,
    output logic [3:0]        word_len_o,
`ifdef NIBBLE_PACK_MAX_EN
    output logic [3:0]        word_max_o,
`endif
    output logic              word_valid_o,
    input  logic              word_ready_i
);
    localparam int W  = 4 * NIBS;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [2:0]    idx_q, idx_d;
    logic [W-1:0]  asm_q, asm_d, merged;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, rd_sel;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  word_mem [FIFO_DEPTH];
    logic [3:0]    len_mem  [FIFO_DEPTH];
    logic          full, empty, last, accept, push, pop;
    logic [3:0]    push_len;

    always_comb begin
        full         = cnt_q == CW'(FIFO_DEPTH);
        empty        = cnt_q == '0;
        last         = idx_q == 3'(NIBS - 1);
        nib_ready_o  = !(full && (last || flush_i));
        accept       = nib_valid_i && nib_ready_o;
        push         = (accept && last) || (flush_i && !full && (idx_q != '0 || accept));
        word_valid_o = !empty;
        pop          = word_valid_o && word_ready_i;
        merged       = accept ? asm_q | (W'(nib_i) << {idx_q, 2'b00}) : asm_q;
        push_len     = {1'b0, idx_q} + {3'b000, accept};
        idx_d        = push ? '0 : accept ? idx_q + 3'd1 : idx_q;
        asm_d        = push ? '0 : merged;
        wr_d         = push ? wr_q + PW'(1) : wr_q;
        rd_d         = pop ? rd_q + PW'(1) : rd_q;
        cnt_d        = cnt_q + CW'(push) - CW'(pop);
        // When empty, the slot behind the read pointer is the last word popped.
        rd_sel       = empty ? rd_q - PW'(1) : rd_q;
        word_o       = word_mem[rd_sel];
        word_len_o   = len_mem[rd_sel];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            asm_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            idx_q <= idx_d;
            asm_q <= asm_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                word_mem[i] <= '0;
                len_mem[i]  <= '0;
            end
        end else if (push) begin
            word_mem[wr_q] <= merged;
            len_mem[wr_q]  <= push_len;
        end
    end

`ifdef NIBBLE_PACK_MAX_EN
    logic [3:0] max_q, max_d, max_new;
    logic [3:0] max_mem [FIFO_DEPTH];

    always_comb begin
        max_new    = (accept && nib_i > max_q) ? nib_i : max_q;
        max_d      = push ? 4'd0 : max_new;
        word_max_o = max_mem[rd_sel];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) max_mem[i] <= '0;
        end else begin
            max_q <= max_d;
            if (push) max_mem[wr_q] <= max_new;
        end
    end
`endif
endmodule
